int_ctrl: RTL and testbench

- Interrupt controller directly upstream of the multi-cycle CPU.
- Collects 4 external device interrupt lines, latches them as pending, masks them and priority-arbitrates.
- Drives the CPU's Ireq / gntInt[3:0] pair and consumes its Iack and interrupt-enable output.
- Provides a small bus-slave register port (mask / pending / status) on the CPU's memory-mapped I/O bus.

---
 rtl/int_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_int_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: 4-source interrupt controller with synchronizers, pending/mask, fixed-priority arbitration,
// CPU Ireq/Iack handshake and a small register slave. Define INTC_LEVEL_EN for level-triggered pending.
module int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  RESET_MASK  = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_i,
  input  logic        int_en_i,
  input  logic        Iack,
  output logic        Ireq,
  output logic [3:0]  gntInt,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned DW    = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] synced_c;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] req_c;
  logic [N_SRC-1:0] arb_c;
  logic [N_SRC-1:0] gnt_q;
  logic [N_SRC-1:0] gnt_n;
  logic [1:0]       state_q;
  logic [1:0]       state_n;
  logic             ireq_q;
  logic             ireq_n;
  logic             en_q;
  logic             wr_mask_c;
  logic [DW-1:0]    rdata_c;
  logic [DW-1:0]    dat_q;
  logic             ack_q;
  logic             unused_c;

  assign unused_c = ^dat_i[DW-1:N_SRC];

  // Multi-flop synchronizer per irq line; last stage is the clean, clk-domain view
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign synced_c = sync_q[SYNC_STAGES-1];

`ifdef INTC_LEVEL_EN
  // Level mode: pending simply tracks the synchronized lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= synced_c;
    end
  end
`else
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise_c;
  logic [N_SRC-1:0] w1c_c;
  logic [N_SRC-1:0] iack_clr_c;

  assign rise_c     = synced_c & ~prev_q;
  assign w1c_c      = (stb_i && we_i && (addr_i == A_PEND)) ? dat_i[N_SRC-1:0] : '0;
  assign iack_clr_c = ((state_q == ST_REQ) && Iack) ? gnt_q : '0;

  // Edge mode: a new rising edge wins over any clear landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= synced_c;
      pend_q <= (pend_q & ~(w1c_c | iack_clr_c)) | rise_c;
    end
  end
`endif

  assign wr_mask_c = stb_i && we_i && (addr_i == A_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= RESET_MASK;
    end else if (wr_mask_c) begin
      mask_q <= dat_i[N_SRC-1:0];
    end
  end

  // Source 0 has highest priority: isolate the lowest set bit
  assign req_c = pend_q & mask_q;
  assign arb_c = req_c & (~req_c + N_SRC'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ireq_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      ireq_q  <= ireq_n;
      en_q    <= int_en_i;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    ireq_n  = ireq_q;
    case (state_q)
      ST_IDLE: begin
        if (int_en_i && (req_c != '0)) begin
          state_n = ST_REQ;
          gnt_n   = arb_c;
          ireq_n  = 1'b1;
        end
      end
      ST_REQ: begin
        if (Iack) begin
          state_n = ST_SERV;
          ireq_n  = 1'b0;
        end
      end
      ST_SERV: begin
        // Handler return is signalled by interrupts being re-enabled
        if (int_en_i && !en_q) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        ireq_n  = 1'b0;
      end
    endcase
  end

  always_comb begin
    rdata_c = '0;
    case (addr_i)
      A_MASK:  rdata_c = {28'b0, mask_q};
      A_PEND:  rdata_c = {28'b0, pend_q};
      A_STAT:  rdata_c = {22'b0, state_q, 4'b0, gnt_q};
      default: rdata_c = '0;
    endcase
  end

  // Single-cycle slave: every strobe is acked one cycle later with its read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= stb_i;
      dat_q <= stb_i ? rdata_c : '0;
    end
  end

  assign Ireq   = ireq_q;
  assign gntInt = gnt_q;
  assign dat_o  = dat_q;
  assign ack_o  = ack_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (edge-latched build): directed scenarios plus a randomized
// service loop checked against a set-level model of pending/mask/priority.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_i;
  logic        int_en_i;
  logic        Iack;
  logic        Ireq;
  logic [3:0]  gntInt;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  int checks;
  int errors;
  logic [31:0] rd;

  int_ctrl #(.SYNC_STAGES(2), .RESET_MASK(4'h0)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .int_en_i(int_en_i), .Iack(Iack),
    .Ireq(Ireq), .gntInt(gntInt), .stb_i(stb_i), .we_i(we_i), .addr_i(addr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] bits);
    irq_i = bits;
    step(1);
    irq_i = 4'h0;
  endtask

  // One register access; also checks the one-cycle ack window
  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] wd, output logic [31:0] rdv);
    stb_i = 1'b1; we_i = we; addr_i = a; dat_i = wd;
    step(1);
    rdv = dat_o;
    checks++;
    if (ack_o !== 1'b1) begin errors++; $display("FAIL ack_high addr=%0d got %b exp 1", a, ack_o); end
    stb_i = 1'b0; we_i = 1'b0; dat_i = 32'h0;
    step(1);
    checks++;
    if (ack_o !== 1'b0 || dat_o !== 32'h0) begin
      errors++; $display("FAIL ack_low addr=%0d got ack=%b dat=%h exp 0/0", a, ack_o, dat_o);
    end
  endtask

  task automatic service_exit();
    int_en_i = 1'b0;
    step(1);
    int_en_i = 1'b1;
    step(1);
    int_en_i = 1'b0;
    checks++;
    if (gntInt !== 4'h0 || Ireq !== 1'b0) begin
      errors++; $display("FAIL exit_idle got gnt=%b ireq=%b exp 0000/0", gntInt, Ireq);
    end
    step(1);
    checks++;
    if (Ireq !== 1'b0) begin errors++; $display("FAIL exit_no_rearb got %b exp 0", Ireq); end
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_i = 4'h0; int_en_i = 1'b0; Iack = 1'b0;
    stb_i = 1'b0; we_i = 1'b0; addr_i = 2'd0; dat_i = 32'h0;
    step(2);
    checks++;
    if (Ireq !== 1'b0 || gntInt !== 4'h0 || ack_o !== 1'b0 || dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got ireq=%b gnt=%b ack=%b dat=%h exp all 0", Ireq, gntInt, ack_o, dat_o);
    end
    reset = 1'b1;
    step(1);
    bus(1'b0, 2'd0, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", rd); end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp 0", rd); end
    bus(1'b0, 2'd2, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
  endtask

  task automatic test_masked_pending();
    int_en_i = 1'b1;
    pulse(4'b0100);
    step(4);
    checks++; if (Ireq !== 1'b0) begin errors++; $display("FAIL masked_ireq got %b exp 0", Ireq); end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL masked_pend got %h exp 4", rd); end
    bus(1'b0, 2'd2, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL masked_status got %h exp 0", rd); end
    bus(1'b1, 2'd1, 32'h4, rd);
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL masked_w1c got %h exp 0", rd); end
    int_en_i = 1'b0;
    step(1);
  endtask

  task automatic test_priority();
    bus(1'b1, 2'd0, 32'hF, rd);
    int_en_i = 1'b1;
    pulse(4'b1010);
    step(3);
    checks++;
    if (Ireq !== 1'b1 || gntInt !== 4'b0010) begin
      errors++; $display("FAIL prio_grant got ireq=%b gnt=%b exp 1/0010", Ireq, gntInt);
    end
    Iack = 1'b1;
    step(1);
    Iack = 1'b0;
    checks++;
    if (Ireq !== 1'b0 || gntInt !== 4'b0010) begin
      errors++; $display("FAIL prio_iack got ireq=%b gnt=%b exp 0/0010", Ireq, gntInt);
    end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL prio_pend got %h exp 8", rd); end
    bus(1'b0, 2'd2, 32'h0, rd);
    checks++; if (rd !== 32'h202) begin errors++; $display("FAIL prio_status_serv got %h exp 202", rd); end
    int_en_i = 1'b0;
    step(1);
    int_en_i = 1'b1;
    step(1);
    checks++;
    if (gntInt !== 4'h0 || Ireq !== 1'b0) begin
      errors++; $display("FAIL prio_return got gnt=%b ireq=%b exp 0000/0", gntInt, Ireq);
    end
    step(1);
    checks++;
    if (Ireq !== 1'b1 || gntInt !== 4'b1000) begin
      errors++; $display("FAIL prio_rearb got ireq=%b gnt=%b exp 1/1000", Ireq, gntInt);
    end
  endtask

  task automatic test_req_hold();
    bus(1'b1, 2'd0, 32'h0, rd);
    int_en_i = 1'b0;
    step(3);
    checks++;
    if (Ireq !== 1'b1 || gntInt !== 4'b1000) begin
      errors++; $display("FAIL hold_req got ireq=%b gnt=%b exp 1/1000", Ireq, gntInt);
    end
    bus(1'b0, 2'd2, 32'h0, rd);
    checks++; if (rd !== 32'h108) begin errors++; $display("FAIL hold_status got %h exp 108", rd); end
    Iack = 1'b1;
    step(1);
    Iack = 1'b0;
    checks++; if (Ireq !== 1'b0) begin errors++; $display("FAIL hold_iack got %b exp 0", Ireq); end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hold_pend got %h exp 0", rd); end
    bus(1'b1, 2'd0, 32'hF, rd);
    service_exit();
  endtask

  task automatic test_iack_collision();
    int_en_i = 1'b1;
    pulse(4'b0001);
    step(3);
    checks++;
    if (Ireq !== 1'b1 || gntInt !== 4'b0001) begin
      errors++; $display("FAIL coll_grant got ireq=%b gnt=%b exp 1/0001", Ireq, gntInt);
    end
    pulse(4'b0001);
    step(1);
    Iack = 1'b1;
    step(1);
    Iack = 1'b0;
    checks++; if (Ireq !== 1'b0) begin errors++; $display("FAIL coll_iack got %b exp 0", Ireq); end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL coll_pend got %h exp 1", rd); end
    service_exit();
    bus(1'b1, 2'd1, 32'h1, rd);
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL coll_clear got %h exp 0", rd); end
  endtask

  task automatic test_w1c();
    bus(1'b1, 2'd0, 32'h0, rd);
    pulse(4'b0111);
    step(3);
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL w1c_set got %h exp 7", rd); end
    bus(1'b1, 2'd1, 32'h5, rd);
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL w1c_partial got %h exp 2", rd); end
    bus(1'b1, 2'd1, 32'hFFFF_FFFF, rd);
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_all got %h exp 0", rd); end
    bus(1'b1, 2'd0, 32'hFFFF_FFF6, rd);
    bus(1'b0, 2'd0, 32'h0, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL mask_upper got %h exp 6", rd); end
    bus(1'b1, 2'd0, 32'h0, rd);
  endtask

  task automatic test_addr3();
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, rd);
    bus(1'b0, 2'd3, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL addr3_read got %h exp 0", rd); end
    bus(1'b1, 2'd2, 32'hFFFF_FFFF, rd);
    bus(1'b0, 2'd2, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_ro got %h exp 0", rd); end
  endtask

  task automatic test_back_to_back();
    bus(1'b1, 2'd0, 32'h9, rd);
    stb_i = 1'b1; we_i = 1'b0; addr_i = 2'd0;
    step(1);
    checks++;
    if (ack_o !== 1'b1 || dat_o !== 32'h9) begin
      errors++; $display("FAIL b2b_first got ack=%b dat=%h exp 1/9", ack_o, dat_o);
    end
    addr_i = 2'd1;
    step(1);
    checks++;
    if (ack_o !== 1'b1 || dat_o !== 32'h0) begin
      errors++; $display("FAIL b2b_second got ack=%b dat=%h exp 1/0", ack_o, dat_o);
    end
    stb_i = 1'b0;
    step(1);
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", ack_o); end
    bus(1'b1, 2'd0, 32'h0, rd);
  endtask

  task automatic test_reset_mid();
    bus(1'b1, 2'd0, 32'hF, rd);
    int_en_i = 1'b1;
    pulse(4'b0100);
    step(3);
    checks++;
    if (Ireq !== 1'b1 || gntInt !== 4'b0100) begin
      errors++; $display("FAIL rmid_req got ireq=%b gnt=%b exp 1/0100", Ireq, gntInt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (Ireq !== 1'b0 || gntInt !== 4'h0) begin
      errors++; $display("FAIL rmid_async got ireq=%b gnt=%b exp 0/0000", Ireq, gntInt);
    end
    step(1);
    reset = 1'b1;
    step(3);
    checks++; if (Ireq !== 1'b0) begin errors++; $display("FAIL rmid_glitch got %b exp 0", Ireq); end
    bus(1'b0, 2'd1, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_pend got %h exp 0", rd); end
    bus(1'b0, 2'd0, 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_mask got %h exp 0", rd); end
    int_en_i = 1'b0;
    step(1);
  endtask

  // Random pulses, clears and masks; model keeps pending as a set and picks its lowest member
  task automatic test_random();
    logic [3:0] pend_m;
    logic [3:0] mask_m;
    logic [3:0] s;
    logic [3:0] w;
    logic [3:0] g;
    pend_m = 4'h0;
    mask_m = 4'h0;
    for (int it = 0; it < 40; it++) begin
      s = 4'($urandom_range(0, 15));
      pulse(s);
      step(3);
      pend_m = pend_m | s;
      if ($urandom_range(0, 1) == 1) begin
        w = 4'($urandom_range(0, 15));
        bus(1'b1, 2'd1, {28'h0, w}, rd);
        pend_m = pend_m & ~w;
      end
      bus(1'b0, 2'd1, 32'h0, rd);
      checks++;
      if (rd !== {28'h0, pend_m}) begin errors++; $display("FAIL rnd_pend it=%0d got %h exp %h", it, rd, pend_m); end
      mask_m = 4'($urandom_range(0, 15));
      bus(1'b1, 2'd0, {28'h0, mask_m}, rd);
      g = 4'h0;
      for (int k = 3; k >= 0; k--) begin
        if (pend_m[k] && mask_m[k]) g = 4'(1) << k;
      end
      int_en_i = 1'b1;
      step(1);
      checks++;
      if (Ireq !== (g != 4'h0) || gntInt !== g) begin
        errors++; $display("FAIL rnd_grant it=%0d got ireq=%b gnt=%b exp %b/%b", it, Ireq, gntInt, (g != 4'h0), g);
      end
      if (g != 4'h0) begin
        Iack = 1'b1;
        step(1);
        Iack = 1'b0;
        pend_m = pend_m & ~g;
        bus(1'b0, 2'd2, 32'h0, rd);
        checks++;
        if (rd !== {22'h0, 2'd2, 4'h0, g}) begin
          errors++; $display("FAIL rnd_status it=%0d got %h exp %h", it, rd, {22'h0, 2'd2, 4'h0, g});
        end
        service_exit();
      end else begin
        int_en_i = 1'b0;
        step(1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_masked_pending();
    test_priority();
    test_req_hold();
    test_iack_collision();
    test_w1c();
    test_addr3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
